// File: rtl/sfp_link_mon_pkg.sv
// Shared types for the SFP link monitor: FSM state encoding and width.
package sfp_link_mon_pkg;

  localparam int unsigned StateWidth = 3;

  typedef enum logic [StateWidth-1:0] {
    StAbsent   = 3'd0,
    StWait     = 3'd1,
    StDebounce = 3'd2,
    StUp       = 3'd3,
    StReset    = 3'd4
  } link_state_e;

endpackage

// File: rtl/sfp_link_mon_sync.sv
// Two-flop synchroniser with asynchronous active-low reset, parameterised width.
module sfp_link_mon_sync #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sfp_link_monitor.sv
// Per-port SFP link supervisor: qualifies PHY status, requests PHY resets, drives LEDs.
// Statistics counters are built only when SFP_LINK_MON_STATS_EN is defined.
module sfp_link_monitor
  import sfp_link_mon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = 65536,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 16777216,
  parameter int unsigned RESET_PULSE_CYCLES  = 256,
  parameter int unsigned BLINK_CYCLES        = 4194304,
  parameter int unsigned STAT_WIDTH          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sfp_npres,
  input  logic                  sfp_los,
  input  logic                  rx_block_lock,
  input  logic                  rx_high_ber,
  input  logic                  rx_activity,
  input  logic                  stats_clear,
  output logic                  link_up,
  output logic                  phy_reset_req,
  output logic [1:0]            led,
  output logic [StateWidth-1:0] state,
  output logic [STAT_WIDTH-1:0] link_up_count,
  output logic [STAT_WIDTH-1:0] link_down_count,
  output logic [STAT_WIDTH-1:0] reset_count
);

  localparam int unsigned MaxA     = (DEBOUNCE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     DEBOUNCE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MaxTimer = (MaxA > RESET_PULSE_CYCLES) ? MaxA : RESET_PULSE_CYCLES;
  localparam int unsigned TimerW   = $clog2(MaxTimer);
  localparam int unsigned BlinkW   = $clog2(BLINK_CYCLES + 1);

  logic [3:0] sync_q;
  logic       npres_s, los_s, lock_s, ber_s, qual;

  sfp_link_mon_sync #(
    .Width(4)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    ({sfp_npres, sfp_los, rx_block_lock, rx_high_ber}),
    .q    (sync_q)
  );

  assign npres_s = sync_q[3];
  assign los_s   = sync_q[2];
  assign lock_s  = sync_q[1];
  assign ber_s   = sync_q[0];
  assign qual    = lock_s & ~ber_s & ~los_s;

  link_state_e       state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              link_up_q, reset_req_q;
  logic [BlinkW-1:0] blink_q, blink_d;
  logic              leave_up;

  // Every terminal compare forces a transition, so the timer can never wrap.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (npres_s) begin
      state_d = StAbsent;
      timer_d = '0;
    end else begin
      unique case (state_q)
        StAbsent: begin
          state_d = StWait;
          timer_d = '0;
        end
        StWait: begin
          if (qual) begin
            state_d = StDebounce;
            timer_d = '0;
          end else if (timer_q == TimerW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            state_d = StReset;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StDebounce: begin
          if (!qual) begin
            state_d = StWait;
            timer_d = '0;
          end else if (timer_q == TimerW'(DEBOUNCE_CYCLES - 1)) begin
            state_d = StUp;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StUp: begin
          if (!qual) begin
            state_d = StWait;
            timer_d = '0;
          end
        end
        StReset: begin
          if (timer_q == TimerW'(RESET_PULSE_CYCLES - 1)) begin
            state_d = StWait;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = StAbsent;
          timer_d = '0;
        end
      endcase
    end
  end

  assign leave_up = (state_q == StUp) && (state_d != StUp);

  always_comb begin
    blink_d = blink_q;
    if (leave_up) begin
      blink_d = '0;
    end else if (rx_activity && link_up_q) begin
      blink_d = BlinkW'(BLINK_CYCLES);
    end else if (blink_q != '0) begin
      blink_d = blink_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAbsent;
      timer_q     <= '0;
      link_up_q   <= 1'b0;
      reset_req_q <= 1'b0;
      blink_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      link_up_q   <= (state_d == StUp);
      reset_req_q <= (state_d == StReset);
      blink_q     <= blink_d;
    end
  end

  assign link_up       = link_up_q;
  assign phy_reset_req = reset_req_q;
  assign led           = {(blink_q != '0) & link_up_q, link_up_q};
  assign state         = state_q;

`ifdef SFP_LINK_MON_STATS_EN
  logic                  up_evt, rst_evt;
  logic [STAT_WIDTH-1:0] up_cnt_q, down_cnt_q, rst_cnt_q;

  assign up_evt  = (state_d == StUp) && (state_q != StUp);
  assign rst_evt = (state_d == StReset) && (state_q != StReset);

  // Clear outranks a coincident increment; counters hold at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_cnt_q   <= '0;
      down_cnt_q <= '0;
      rst_cnt_q  <= '0;
    end else if (stats_clear) begin
      up_cnt_q   <= '0;
      down_cnt_q <= '0;
      rst_cnt_q  <= '0;
    end else begin
      if (up_evt && !(&up_cnt_q))     up_cnt_q   <= up_cnt_q + 1'b1;
      if (leave_up && !(&down_cnt_q)) down_cnt_q <= down_cnt_q + 1'b1;
      if (rst_evt && !(&rst_cnt_q))   rst_cnt_q  <= rst_cnt_q + 1'b1;
    end
  end

  assign link_up_count   = up_cnt_q;
  assign link_down_count = down_cnt_q;
  assign reset_count     = rst_cnt_q;
`else
  logic unused_stats_clear;
  assign unused_stats_clear = stats_clear;
  assign link_up_count      = '0;
  assign link_down_count    = '0;
  assign reset_count        = '0;
`endif

endmodule

// File: tb/tb_sfp_link_monitor.sv
// Directed self-checking bench for sfp_link_monitor with shortened timing parameters.
module tb_sfp_link_monitor;

`ifdef SFP_LINK_MON_STATS_EN
  localparam int StatsEn = 1;
`else
  localparam int StatsEn = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sfp_npres = 1'b0;
  logic       sfp_los = 1'b0;
  logic       rx_block_lock = 1'b0;
  logic       rx_high_ber = 1'b0;
  logic       rx_activity = 1'b0;
  logic       stats_clear = 1'b0;
  logic       link_up;
  logic       phy_reset_req;
  logic [1:0] led;
  logic [2:0] state;
  logic [3:0] link_up_count;
  logic [3:0] link_down_count;
  logic [3:0] reset_count;

  int checks = 0;
  int failures = 0;

  sfp_link_monitor #(
    .DEBOUNCE_CYCLES    (16),
    .LOCK_TIMEOUT_CYCLES(64),
    .RESET_PULSE_CYCLES (4),
    .BLINK_CYCLES       (8),
    .STAT_WIDTH         (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sfp_npres      (sfp_npres),
    .sfp_los        (sfp_los),
    .rx_block_lock  (rx_block_lock),
    .rx_high_ber    (rx_high_ber),
    .rx_activity    (rx_activity),
    .stats_clear    (stats_clear),
    .link_up        (link_up),
    .phy_reset_req  (phy_reset_req),
    .led            (led),
    .state          (state),
    .link_up_count  (link_up_count),
    .link_down_count(link_down_count),
    .reset_count    (reset_count)
  );

  always #4 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Leaves the bench 1 ns after a rising edge, where outputs are sampled and inputs driven.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_link(input logic exp, input int budget, input string tag);
    int n = 0;
    while (link_up !== exp && n < budget) begin
      tick(1);
      n++;
    end
    check_eq(tag, 32'(link_up), 32'(exp));
  endtask

  function automatic int st(input int n);
    return (StatsEn != 0) ? n : 0;
  endfunction

  initial begin
    // 1: clean link from reset, UP entered on the 19th edge after release
    sfp_npres = 1'b0; rx_block_lock = 1'b1;
    apply_reset();
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_led", 32'(led), 0);
    tick(18);
    check_eq("t1_not_yet", 32'(link_up), 0);
    check_eq("t1_state_deb", 32'(state), 2);
    tick(1);
    check_eq("t1_link_up", 32'(link_up), 1);
    check_eq("t1_led", 32'(led), 1);
    check_eq("t1_state_up", 32'(state), 3);
    check_eq("t1_up_count", 32'(link_up_count), st(1));

    // 2: three-cycle lock glitch
    rx_block_lock = 1'b0;
    tick(2);
    check_eq("t2_still_up", 32'(link_up), 1);
    tick(1);
    rx_block_lock = 1'b1;
    check_eq("t2_dropped", 32'(link_up), 0);
    check_eq("t2_state_wait", 32'(state), 1);
    check_eq("t2_down_count", 32'(link_down_count), st(1));
    tick(18);
    check_eq("t2_not_reup", 32'(link_up), 0);
    tick(1);
    check_eq("t2_reup", 32'(link_up), 1);
    check_eq("t2_up_count", 32'(link_up_count), st(2));

    // 4: activity pulses at t=0 and t=5, LED stretched until t=13
    check_eq("t4_idle_led", 32'(led), 1);
    for (int i = 0; i <= 13; i++) begin
      if (i == 0 || i == 5) rx_activity = 1'b1;
      tick(1);
      rx_activity = 1'b0;
      check_eq($sformatf("t4_led_%0d", i), 32'(led), (i < 13) ? 3 : 1);
    end

    // 3: lock never comes, periodic PHY reset pulses
    rx_block_lock = 1'b0;
    apply_reset();
    tick(64);
    check_eq("t3_req_pre", 32'(phy_reset_req), 0);
    tick(1);
    check_eq("t3_req_on", 32'(phy_reset_req), 1);
    check_eq("t3_state_rst", 32'(state), 4);
    check_eq("t3_rst_count1", 32'(reset_count), st(1));
    tick(3);
    check_eq("t3_req_last", 32'(phy_reset_req), 1);
    tick(1);
    check_eq("t3_req_off", 32'(phy_reset_req), 0);
    check_eq("t3_state_wait", 32'(state), 1);
    tick(63);
    check_eq("t3_req_pre2", 32'(phy_reset_req), 0);
    tick(1);
    check_eq("t3_req_on2", 32'(phy_reset_req), 1);
    check_eq("t3_rst_count2", 32'(reset_count), st(2));

    // 6a: module removed mid-RESET
    sfp_npres = 1'b1;
    tick(3);
    check_eq("t6_rst_state", 32'(state), 0);
    check_eq("t6_rst_req", 32'(phy_reset_req), 0);

    // 6b: module removed mid-UP
    sfp_npres = 1'b0; rx_block_lock = 1'b1;
    apply_reset();
    tick(19);
    check_eq("t6_up", 32'(link_up), 1);
    sfp_npres = 1'b1;
    tick(2);
    check_eq("t6_up_hold", 32'(link_up), 1);
    tick(1);
    check_eq("t6_up_state", 32'(state), 0);
    check_eq("t6_up_link", 32'(link_up), 0);
    check_eq("t6_up_led", 32'(led), 0);
    check_eq("t6_down_count", 32'(link_down_count), st(1));

    // 6c: async reset asserted mid-DEBOUNCE clears everything at once
    sfp_npres = 1'b0;
    tick(8);
    check_eq("t6_deb_state", 32'(state), 2);
    rst_n = 1'b0;
    #1;
    check_eq("t6_ar_state", 32'(state), 0);
    check_eq("t6_ar_req", 32'(phy_reset_req), 0);
    check_eq("t6_ar_led", 32'(led), 0);
    check_eq("t6_ar_up_count", 32'(link_up_count), 0);
    check_eq("t6_ar_down_count", 32'(link_down_count), 0);

    // 5: 20 up/down cycles saturate the counters; clear beats a coincident increment
    rx_block_lock = 1'b1;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      wait_link(1'b1, 40, $sformatf("t5_up_%0d", i));
      rx_block_lock = 1'b0;
      wait_link(1'b0, 10, $sformatf("t5_down_%0d", i));
      rx_block_lock = 1'b1;
    end
    check_eq("t5_up_sat", 32'(link_up_count), st(15));
    check_eq("t5_down_sat", 32'(link_down_count), st(15));
    stats_clear = 1'b1;
    tick(1);
    stats_clear = 1'b0;
    check_eq("t5_cleared", 32'(link_down_count), 0);
    tick(17);
    check_eq("t5_pre_up", 32'(link_up), 0);
    stats_clear = 1'b1;
    tick(1);
    stats_clear = 1'b0;
    check_eq("t5_up_with_clear", 32'(link_up), 1);
    check_eq("t5_clear_wins", 32'(link_up_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
